// File: rtl/gray_pkg.sv
// Shared types and constants for the Bayer-to-grayscale converter:
// operating modes, Bayer phases and the fixed-point luma weights.
package gray_pkg;

  typedef enum logic {
    AVG  = 1'b0,
    LUMA = 1'b1
  } gray_mode_e;

  typedef enum logic [1:0] {
    RGGB = 2'd0,
    GRBG = 2'd1,
    GBRG = 2'd2,
    BGGR = 2'd3
  } bayer_pat_e;

  // Luma weights in 1/256 units; they add up to exactly 256.
  localparam int unsigned COEF_R     = 77;
  localparam int unsigned COEF_G     = 75;
  localparam int unsigned COEF_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

endpackage

// File: rtl/gray_line_buf.sv
// One-line delay for the Bayer stream: tap returns the sample that was
// accepted exactly LINE_W enabled cycles earlier. RAM contents are not reset.
module gray_line_buf #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 1280
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              clken,
  input  logic [DATA_W-1:0] shiftin,
  output logic [DATA_W-1:0] tap
);

  localparam int PTR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  logic [DATA_W-1:0] mem [LINE_W];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;

  // Read-before-write on the same slot gives the full LINE_W delay.
  assign tap = mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (clken) begin
      ptr_d = (ptr_q == PTR_W'(LINE_W - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (clken) begin
      mem[ptr_q] <= shiftin;
    end
  end

endmodule

// File: rtl/gray_bayer_conv.sv
// Raw Bayer to half-resolution grayscale, two pipeline stages per 2x2 window.
// Optional threshold output oBin is built only with GRAY_BAYER_BIN_EN defined.
module gray_bayer_conv
  import gray_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int LINE_W  = 1280,
  parameter int PATTERN = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [10:0]       iX_Cont,
  input  logic [10:0]       iY_Cont,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iMODE,
`ifdef GRAY_BAYER_BIN_EN
  input  logic [DATA_W-1:0] iThresh,
  output logic              oBin,
`endif
  output logic [DATA_W-1:0] oGray,
  output logic              oDVAL,
  output logic [9:0]        oX,
  output logic [9:0]        oY
);

  localparam logic [1:0] PAT    = 2'(PATTERN);
  localparam int         SUM_W  = DATA_W + 2;
  localparam int         LUMA_W = DATA_W + 8;

  logic [DATA_W-1:0] tap;
  logic [DATA_W-1:0] p10_q, p00_q;
  logic              winDone;

  logic              s1Valid_q;
  logic [DATA_W-1:0] s1P00_q, s1P01_q, s1P10_q, s1P11_q;
  gray_mode_e        s1Mode_q;
  logic [9:0]        s1X_q, s1Y_q;
`ifdef GRAY_BAYER_BIN_EN
  logic [DATA_W-1:0] s1Thresh_q;
`endif

  logic [DATA_W-1:0] r, g1, g2, b;
  logic [SUM_W-1:0]  avgSum;
  logic [LUMA_W-1:0] lumaSum;
  logic [DATA_W-1:0] gray_d;

  gray_line_buf #(
    .DATA_W(DATA_W),
    .LINE_W(LINE_W)
  ) u_line_buf (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .clken   (iDVAL),
    .shiftin (iDATA),
    .tap     (tap)
  );

  // Bottom-right pixel of a 2x2 block closes the window.
  assign winDone = iDVAL & iX_Cont[0] & iY_Cont[0];

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      p10_q <= '0;
      p00_q <= '0;
    end else if (iDVAL) begin
      p10_q <= iDATA;
      p00_q <= tap;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s1Valid_q <= 1'b0;
      s1P00_q   <= '0;
      s1P01_q   <= '0;
      s1P10_q   <= '0;
      s1P11_q   <= '0;
      s1Mode_q  <= AVG;
      s1X_q     <= '0;
      s1Y_q     <= '0;
`ifdef GRAY_BAYER_BIN_EN
      s1Thresh_q <= '0;
`endif
    end else begin
      s1Valid_q <= winDone;
      if (winDone) begin
        s1P00_q  <= p00_q;
        s1P01_q  <= tap;
        s1P10_q  <= p10_q;
        s1P11_q  <= iDATA;
        s1Mode_q <= gray_mode_e'(iMODE);
        s1X_q    <= iX_Cont[10:1];
        s1Y_q    <= iY_Cont[10:1];
`ifdef GRAY_BAYER_BIN_EN
        s1Thresh_q <= iThresh;
`endif
      end
    end
  end

  // Window slots are top-left P00, top-right P01, bottom-left P10, bottom-right P11.
  always_comb begin
    r  = s1P00_q;
    g1 = s1P01_q;
    g2 = s1P10_q;
    b  = s1P11_q;
    case (PAT)
      GRBG: begin g1 = s1P00_q; r  = s1P01_q; b  = s1P10_q; g2 = s1P11_q; end
      GBRG: begin g1 = s1P00_q; b  = s1P01_q; r  = s1P10_q; g2 = s1P11_q; end
      BGGR: begin b  = s1P00_q; g1 = s1P01_q; g2 = s1P10_q; r  = s1P11_q; end
      default: ;
    endcase
    avgSum  = SUM_W'(s1P00_q) + SUM_W'(s1P01_q) + SUM_W'(s1P10_q) + SUM_W'(s1P11_q);
    lumaSum = LUMA_W'(COEF_R) * LUMA_W'(r)
            + LUMA_W'(COEF_G) * (LUMA_W'(g1) + LUMA_W'(g2))
            + LUMA_W'(COEF_B) * LUMA_W'(b);
    gray_d  = (s1Mode_q == LUMA) ? DATA_W'(lumaSum >> LUMA_SHIFT) : avgSum[SUM_W-1:2];
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL <= 1'b0;
      oGray <= '0;
      oX    <= '0;
      oY    <= '0;
`ifdef GRAY_BAYER_BIN_EN
      oBin  <= 1'b0;
`endif
    end else begin
      oDVAL <= s1Valid_q;
      if (s1Valid_q) begin
        oGray <= gray_d;
        oX    <= s1X_q;
        oY    <= s1Y_q;
`ifdef GRAY_BAYER_BIN_EN
        oBin  <= (gray_d >= s1Thresh_q);
`endif
      end
    end
  end

endmodule

// File: doc/gray_bayer_conv.md
GRAY_BAYER_CONV -- requirements
Module: gray_bayer_conv

Interface
REQ-001 Parameter DATA_W, default 12: bit width of raw Bayer samples and of oGray.
REQ-002 Parameter LINE_W, default 1280: active pixels per line, which is the line-buffer depth.
REQ-003 Parameter PATTERN, default 0: Bayer phase of the 2x2 window (0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR).
REQ-004 iCLK  input  1  clock; all state updates on the rising edge.
REQ-005 iRST  input  1  reset, asynchronous, active-low.
REQ-006 iX_Cont  input  11  column index of iDATA.
REQ-007 iY_Cont  input  11  row index of iDATA.
REQ-008 iDATA  input  DATA_W  raw Bayer sample.
REQ-009 iDVAL  input  1  iDATA/iX_Cont/iY_Cont valid this cycle.
REQ-010 iMODE  input  1  0 = 2x2 average, 1 = weighted luma; sampled with each window.
REQ-011 oGray  output  DATA_W  grayscale result.
REQ-012 oDVAL  output  1  oGray, oX and oY valid; single-cycle pulse per window.
REQ-013 oX  output  10  decimated column, equal to iX_Cont[10:1] of the completing pixel.
REQ-014 oY  output  10  decimated row, equal to iY_Cont[10:1] of the completing pixel.

Function
REQ-015 The line buffer SHALL shift only when iDVAL=1, delaying iDATA by exactly LINE_W accepted samples.
REQ-016 Window: P11=iDATA, P10=previous accepted iDATA, P01=line-buffer tap, P00=previous accepted tap.
REQ-017 A window is complete when iDVAL=1 and iY_Cont[0]=1 and iX_Cont[0]=1; all other accepted pixels SHALL produce no output.
REQ-018 Stage 1 SHALL register the window, iMODE, and the coordinates; stage 2 SHALL register oGray/oX/oY and assert oDVAL.
REQ-019 Latency: oDVAL is high exactly 2 cycles after the completing pixel is accepted; throughput is 1 window/cycle.
REQ-020 Mode 0: oGray = (P00+P01+P10+P11)>>2, summed at DATA_W+2 bits, truncated.
REQ-021 Mode 1: oGray = (77*R + 75*(G1+G2) + 29*B)>>8, computed at DATA_W+8 bits, truncated. R/G1/G2/B are mapped from P00..P11 per PATTERN.
REQ-022 Coefficients sum to 256, so no clamping is needed: the output never exceeds 2^DATA_W-1.
REQ-023 iDVAL gaps SHALL stall the window and line buffer; no output is produced during gaps, and no data is lost.
REQ-024 Row 0 (iY_Cont[0]=0) SHALL never produce output.
REQ-025 Outputs on the first odd row after reset use unreset line-buffer contents; such values are don't-care to the bench.
REQ-026 Coordinates beyond LINE_W-1 are out of contract.

Reset
REQ-027 While iRST=0: oGray=0, oDVAL=0, oX=0, oY=0, and all pipeline and delay registers are 0.
REQ-028 Reset mid-frame SHALL cancel in-flight windows; oDVAL stays 0 until a new complete window passes both stages.
REQ-029 Line-buffer RAM contents are not reset.

Configuration
REQ-030 With macro GRAY_BAYER_BIN_EN defined, the block adds iThresh (input, DATA_W) and oBin (output, 1).
REQ-031 When enabled, oBin is registered with oGray and equals (stage-2 gray >= iThresh); iThresh is sampled in stage 1; oBin resets to 0.
REQ-032 With GRAY_BAYER_BIN_EN undefined, iThresh and oBin are absent and no compare logic is synthesised.

Structure
REQ-033 Package gray_pkg SHALL hold the mode enum (AVG, LUMA), the pattern enum, coefficient constants 77/75/29, and the shift constant 8.
REQ-034 Sub-module gray_line_buf (parameters DATA_W, LINE_W; ports clken, shiftin, tap) SHALL implement the one-line delay.
REQ-035 Arithmetic and PATTERN mapping stay in gray_bayer_conv.

Verification
REQ-036 All pixels 100, mode 0 and mode 1 -> every oGray = 100, one oDVAL per 2x2 block.
REQ-037 RGGB, R=4095, G=B=0 -> mode 0 oGray=1023; mode 1 oGray=1231.
REQ-038 PATTERN=3 with the same plane values placed per BGGR -> mode 1 oGray=1231.
REQ-039 Random iDVAL gaps (50%) -> output sequence identical to a gap-free run; each oDVAL is 2 cycles after its completing pixel.
REQ-040 iRST pulsed while a window is in stage 1 -> no oDVAL for that window; all outputs read 0 during reset.
REQ-041 GRAY_BAYER_BIN_EN, iThresh=500, gray values 499/500 -> oBin = 0/1.
